// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone-classic arbiter: core and host share one memory port.
// Round-robin on ties, bus lock for the whole cyc, core freeze via hold,
// and an ack watchdog that terminates stalled strobes with ERR_DATA.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | nobody owns the memory; arbitrate pending requests
// OWN_CORE | core owns the memory until it drops core_cyc_i
// OWN_HOST | host owns the memory until it drops host_cyc_i
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 64,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA = {DATA_WIDTH{1'b1}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_cyc_i,
   input  logic                  core_stb_i,
   input  logic                  core_we_i,
   input  logic [ADDR_WIDTH-1:0] core_addr_i,
   input  logic [DATA_WIDTH-1:0] core_data_i,
   output logic [DATA_WIDTH-1:0] core_data_o,
   output logic                  core_ack_o,
   input  logic                  host_cyc_i,
   input  logic                  host_stb_i,
   input  logic                  host_we_i,
   input  logic [ADDR_WIDTH-1:0] host_addr_i,
   input  logic [DATA_WIDTH-1:0] host_data_i,
   output logic [DATA_WIDTH-1:0] host_data_o,
   output logic                  host_ack_o,
   input  logic                  core_hold_i,
   output logic                  mem_cyc_o,
   output logic                  mem_stb_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_ack_i,
   output logic [1:0]            grant_o,
   output logic                  timeout_o
);

   localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   // Encoding doubles as the one-hot {host,core} grant vector.
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      OWN_CORE = 2'b01,
      OWN_HOST = 2'b10
   } state_t;

   state_t         state_q, state_d;
   logic           last_host_q, last_host_d;   // 1 = host owned last
   logic [WDW-1:0] wd_q, wd_d;
   logic           timeout_q, timeout_d;

   logic core_req, host_req;
   logic owner_stb;
   logic wd_fire;
   logic ack_eff;
   logic [DATA_WIDTH-1:0] rdata_eff;

   assign core_req = core_cyc_i & core_stb_i & ~core_hold_i;
   assign host_req = host_cyc_i & host_stb_i;

   assign owner_stb = (state_q == OWN_CORE) ? core_stb_i :
                      (state_q == OWN_HOST) ? host_stb_i : 1'b0;

   // A real ack in the terminal cycle wins over the forced termination.
   assign wd_fire   = owner_stb & ~mem_ack_i & (wd_q == WD_LAST);
   assign ack_eff   = (owner_stb & mem_ack_i) | wd_fire;
   assign rdata_eff = wd_fire ? ERR_DATA : mem_data_i;

   assign grant_o   = state_q;
   assign timeout_o = timeout_q;

   // State, round-robin memory, watchdog and sticky timeout registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_host_q <= 1'b1;
         wd_q        <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_host_q <= last_host_d;
         wd_q        <= wd_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state: arbitrate in IDLE, hold ownership until the owner's cyc drops.
   always_comb begin
      state_d     = state_q;
      last_host_d = last_host_q;
      case (state_q)
         IDLE: begin
            if (core_req && host_req)
               state_d = last_host_q ? OWN_CORE : OWN_HOST;
            else if (core_req)
               state_d = OWN_CORE;
            else if (host_req)
               state_d = OWN_HOST;
         end
         OWN_CORE: begin
            if (!core_cyc_i) begin
               state_d     = IDLE;
               last_host_d = 1'b0;
            end
         end
         OWN_HOST: begin
            if (!host_cyc_i) begin
               state_d     = IDLE;
               last_host_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Watchdog: count stalled strobe cycles, restart on any ack or when idle.
   always_comb begin
      wd_d      = wd_q;
      timeout_d = timeout_q | wd_fire;
      if (state_q == IDLE || ack_eff)
         wd_d = '0;
      else if (owner_stb)
         wd_d = wd_q + WDW'(1);
   end

   // Output mux: owner's bus goes straight to memory, memory reply to owner only.
   always_comb begin
      mem_cyc_o   = 1'b0;
      mem_stb_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      core_ack_o  = 1'b0;
      core_data_o = '0;
      host_ack_o  = 1'b0;
      host_data_o = '0;
      case (state_q)
         OWN_CORE: begin
            mem_cyc_o   = core_cyc_i;
            mem_stb_o   = core_stb_i;
            mem_we_o    = core_we_i;
            mem_addr_o  = core_addr_i;
            mem_data_o  = core_data_i;
            core_ack_o  = ack_eff;
            core_data_o = rdata_eff;
         end
         OWN_HOST: begin
            mem_cyc_o   = host_cyc_i;
            mem_stb_o   = host_stb_i;
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_data_o  = host_data_i;
            host_ack_o  = ack_eff;
            host_data_o = rdata_eff;
         end
         default: ;
      endcase
   end

endmodule
